// File: rtl/muldiv_if.sv
// Handshake and data bundle between the EX stage and the multiply/divide unit.
// The unit connects through the slave modport; the driving stage uses master.
interface muldiv_if #(
   parameter int DATA_W = 32
);
   logic              start;
   logic [1:0]        op;
   logic [DATA_W-1:0] a_in;
   logic [DATA_W-1:0] b_in;
   logic              mthi;
   logic              mtlo;
   logic [DATA_W-1:0] wdata;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] hi_out;
   logic [DATA_W-1:0] lo_out;

   modport master (
      output start, op, a_in, b_in, mthi, mtlo, wdata,
      input  busy, done, hi_out, lo_out
   );

   modport slave (
      input  start, op, a_in, b_in, mthi, mtlo, wdata,
      output busy, done, hi_out, lo_out
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit owning HI/LO; 32 magnitude steps plus one
// sign-fix cycle.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for start; MTHI/MTLO writes accepted here
//   S_RUN  | one shift-add or restoring-subtract step per cycle
//   S_FIX  | sign correction, HI/LO write, done pulse on the next cycle
module muldiv_unit #(
   parameter int DATA_W = 32
) (
   input  logic     clk,
   input  logic     rst_n,
   muldiv_if.slave  bus
);
   localparam int CNT_W = 6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                is_div_q, is_div_d;
   logic                neg_res_q, neg_res_d;
   logic                neg_rem_q, neg_rem_d;
   logic [DATA_W-1:0]   acc_hi_q, acc_hi_d;
   logic [DATA_W-1:0]   acc_lo_q, acc_lo_d;
   logic [DATA_W-1:0]   mag_b_q, mag_b_d;
   logic [DATA_W-1:0]   hi_q, hi_d;
   logic [DATA_W-1:0]   lo_q, lo_d;
   logic                done_q, done_d;

   logic                is_signed;
   logic [DATA_W-1:0]   mag_a_in, mag_b_in;
   logic [DATA_W:0]     mul_sum;
   logic [DATA_W:0]     div_shift;
   logic                div_ge;
   logic [DATA_W-1:0]   div_diff;
   logic [2*DATA_W-1:0] prod;
   logic [DATA_W-1:0]   quo, rem;

   // op[0]=0 selects the signed forms (MULT, DIV); |0x80000000| stays 0x80000000
   assign is_signed = ~bus.op[0];
   assign mag_a_in  = (is_signed && bus.a_in[DATA_W-1]) ? -bus.a_in : bus.a_in;
   assign mag_b_in  = (is_signed && bus.b_in[DATA_W-1]) ? -bus.b_in : bus.b_in;

   assign mul_sum   = {1'b0, acc_hi_q} +
                      (acc_lo_q[0] ? {1'b0, mag_b_q} : {(DATA_W+1){1'b0}});
   assign div_shift = {acc_hi_q, acc_lo_q[DATA_W-1]};
   assign div_ge    = div_shift >= {1'b0, mag_b_q};
   // partial remainder stays below the divisor, so the low word of the difference is exact
   assign div_diff  = div_shift[DATA_W-1:0] - mag_b_q;

   assign prod = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
   assign quo  = neg_res_q ? -acc_lo_q : acc_lo_q;
   assign rem  = neg_rem_q ? -acc_hi_q : acc_hi_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      mag_b_d   = mag_b_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d   = S_RUN;
               cnt_d     = CNT_W'(DATA_W);
               is_div_d  = bus.op[1];
               neg_res_d = is_signed & (bus.a_in[DATA_W-1] ^ bus.b_in[DATA_W-1]);
               neg_rem_d = is_signed & bus.a_in[DATA_W-1];
               acc_hi_d  = '0;
               acc_lo_d  = mag_a_in;
               mag_b_d   = mag_b_in;
            end else begin
               if (bus.mthi) hi_d = bus.wdata;
               if (bus.mtlo) lo_d = bus.wdata;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q - 1'b1;
            if (is_div_q) begin
               acc_hi_d = div_ge ? div_diff : div_shift[DATA_W-1:0];
               acc_lo_d = {acc_lo_q[DATA_W-2:0], div_ge};
            end else begin
               acc_hi_d = mul_sum[DATA_W:1];
               acc_lo_d = {mul_sum[0], acc_lo_q[DATA_W-1:1]};
            end
            if (cnt_q == CNT_W'(1)) state_d = S_FIX;
         end
         S_FIX: begin
            if (is_div_q) begin
               lo_d = quo;
               hi_d = rem;
            end else begin
               {hi_d, lo_d} = prod;
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         mag_b_q   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         acc_hi_q  <= acc_hi_d;
         acc_lo_q  <= acc_lo_d;
         mag_b_q   <= mag_b_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   assign bus.busy   = (state_q != S_IDLE);
   assign bus.done   = done_q;
   assign bus.hi_out = hi_q;
   assign bus.lo_out = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes reference {HI,LO} results,
// a monitor pops and compares them on every done pulse.
module tb_muldiv_unit;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   muldiv_if #(.DATA_W(32)) bus ();
   muldiv_unit #(.DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   int          checks   = 0;
   int          failures = 0;
   logic [63:0] exp_q[$];
   logic [63:0] mon_e;
   logic [31:0] exp_hi = 32'h0;
   logic [31:0] exp_lo = 32'h0;
   bit          prev_done = 1'b0;
   logic [31:0] corners[6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                               32'h7FFF_FFFF, 32'hFFFF_FFFE};

   // Reference: plain 64-bit arithmetic with the architectural divide-by-zero rules
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
      longint      sa, sbv, q, r;
      logic [63:0] ua, ub;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      ua  = {32'h0, a};
      ub  = {32'h0, b};
      case (o)
         2'b00: return 64'(sa * sbv);
         2'b01: return ua * ub;
         2'b10: begin
            if (b == 32'h0) return {a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
            q = sa / sbv;
            r = sa % sbv;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               mon_e = exp_q.pop_front();
               chk("result_hi", bus.hi_out, mon_e[63:32]);
               chk("result_lo", bus.lo_out, mon_e[31:0]);
            end
         end
         if (prev_done) chk("done_width", 32'(bus.done), 32'h0);
         prev_done = (bus.done === 1'b1);
      end
   end

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit now, input bit inject, input bit with_mtlo);
      logic [63:0] r;
      int          n;
      if (!now) @(negedge clk);
      bus.start = 1'b1;
      bus.op    = o;
      bus.a_in  = a;
      bus.b_in  = b;
      bus.mtlo  = with_mtlo;
      bus.wdata = 32'hDEAD_BEEF;
      r = model(o, a, b);
      exp_q.push_back(r);
      exp_hi = r[63:32];
      exp_lo = r[31:0];
      @(negedge clk);
      bus.start = 1'b0;
      bus.mtlo  = 1'b0;
      bus.op    = 2'($urandom);
      bus.a_in  = $urandom;
      bus.b_in  = $urandom;
      n = 0;
      while (bus.busy === 1'b1 && n < 100) begin
         if (inject && n == 10) begin
            bus.start = 1'b1;
            bus.op    = 2'b01;
            bus.a_in  = 32'h1234_5678;
            bus.b_in  = 32'h9;
         end else if (inject && n == 12) begin
            bus.mtlo  = 1'b1;
            bus.wdata = 32'hA5A5_A5A5;
         end else begin
            bus.start = 1'b0;
            bus.mtlo  = 1'b0;
         end
         n++;
         @(negedge clk);
      end
      bus.start = 1'b0;
      bus.mtlo  = 1'b0;
      chk("busy_cycles", 32'(n), 32'd33);
      chk("done_at_end", 32'(bus.done), 32'h1);
   endtask

   initial begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.a_in  = '0;
      bus.b_in  = '0;
      bus.mthi  = 1'b0;
      bus.mtlo  = 1'b0;
      bus.wdata = '0;
      #1;
      chk("reset_busy", 32'(bus.busy), 32'h0);
      chk("reset_done", 32'(bus.done), 32'h0);
      chk("reset_hi", bus.hi_out, 32'h0);
      chk("reset_lo", bus.lo_out, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
      run_op(2'b00, 32'hFFFF_FFFD, 32'h5, 1, 0, 0);
      run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1, 0, 0);
      run_op(2'b10, 32'hFFFF_FFF9, 32'h2, 0, 0, 0);
      run_op(2'b10, 32'h7, 32'hFFFF_FFFE, 0, 0, 0);
      run_op(2'b11, 32'd100, 32'd7, 0, 0, 0);
      run_op(2'b11, 32'h1234_5678, 32'h0, 0, 0, 0);
      run_op(2'b10, 32'hFFFF_FFF0, 32'h0, 0, 0, 0);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
      run_op(2'b10, 32'h0000_0042, 32'h0, 0, 0, 0);

      run_op(2'b00, 32'h1357_9BDF, 32'hFEDC_BA98, 0, 1, 0);
      chk("mtlo_busy_ignored", bus.lo_out, exp_lo);

      @(negedge clk);
      bus.mthi  = 1'b1;
      bus.wdata = 32'h5A5A_5A5A;
      @(negedge clk);
      bus.mthi = 1'b0;
      chk("mthi_idle_hi", bus.hi_out, 32'h5A5A_5A5A);
      chk("mthi_idle_lo", bus.lo_out, exp_lo);
      exp_hi = 32'h5A5A_5A5A;

      bus.mthi  = 1'b1;
      bus.mtlo  = 1'b1;
      bus.wdata = 32'h0F0F_1234;
      @(negedge clk);
      bus.mthi = 1'b0;
      bus.mtlo = 1'b0;
      chk("mt_both_hi", bus.hi_out, 32'h0F0F_1234);
      chk("mt_both_lo", bus.lo_out, 32'h0F0F_1234);

      run_op(2'b11, 32'hCAFE_0001, 32'h3, 0, 0, 1);
      chk("start_mtlo_lo", bus.lo_out, 32'hCAFE_0001 / 32'h3);

      @(negedge clk);
      bus.mthi  = 1'b1;
      bus.wdata = 32'h7777_0000;
      @(negedge clk);
      bus.mthi  = 1'b0;
      bus.start = 1'b1;
      bus.op    = 2'b10;
      bus.a_in  = 32'h8765_4321;
      bus.b_in  = 32'h13;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (16) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midreset_busy", 32'(bus.busy), 32'h0);
      chk("midreset_done", 32'(bus.done), 32'h0);
      chk("midreset_hi", bus.hi_out, 32'h0);
      chk("midreset_lo", bus.lo_out, 32'h0);
      exp_hi = 32'h0;
      exp_lo = 32'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_op(2'b01, 32'd3, 32'd4, 0, 0, 0);

      for (int i = 0; i < 24; i++) begin
         ro = 2'($urandom);
         ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
         rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
         if ($urandom_range(0, 7) == 0) rb = $urandom_range(1, 9);
         run_op(ro, ra, rb, bit'($urandom_range(0, 1)), 0, 0);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
